// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller: FSM state
// encodings, default geometry/timing and a small state-decode helper.
package sram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int          DEFAULT_ADDR_W      = 18;
  localparam int          DEFAULT_WAIT_CYCLES = 1;
  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;

  // True while a half-word phase is on the SRAM bus.
  function automatic logic in_phase(state_e s);
    return (s == ST_LO) || (s == ST_HI);
  endfunction

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Bundles the CPU-side load/store handshake and the external SRAM pins.
// master = core + SRAM device side, slave = the controller.
interface sram_mem_ctrl_if
  import sram_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              mem_read;
  logic              mem_write;
  logic [31:0]       address;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_out;
  logic [15:0]       sram_dq_in;
  logic              sram_dq_oe;
  logic              sram_we_n;

  modport master (
    output mem_read, mem_write, address, wdata, sram_dq_in,
    input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  mem_read, mem_write, address, wdata, sram_dq_in,
    output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory controller: 32-bit loads/stores as two 16-bit phases
// on an async SRAM. Optional SRAM_POSTED_WRITE_EN adds a one-entry posted store buffer.
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int          ADDR_W      = DEFAULT_ADDR_W,
  parameter int          WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic           clk,
  input  logic           rst,
  sram_mem_ctrl_if.slave bus
);

  localparam int               CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              request;
  logic              last;

  logic              wr_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [15:0]       lo_buf;

  logic              cur_wr;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic [31:0]       offset;
  logic [ADDR_W-1:0] lo_addr;
  logic [ADDR_W-1:0] hi_addr;
  logic              unused_offset;

  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [15:0]       dq_out_q;
  logic              dq_oe_q;
  logic              we_n_q;
  logic              ready_c;

  assign request = bus.mem_read | bus.mem_write;
  assign last    = (cnt == CNT_LAST);

  // In IDLE the request is taken straight from the bus so the first phase
  // can be set up on the accepting edge; afterwards the latched copy is used.
  assign cur_wr    = (state == ST_IDLE) ? bus.mem_write : wr_q;
  assign cur_addr  = (state == ST_IDLE) ? bus.address   : addr_q;
  assign cur_wdata = (state == ST_IDLE) ? bus.wdata     : wdata_q;

  assign offset        = cur_addr - BASE_ADDR;
  assign lo_addr       = {offset[ADDR_W:2], 1'b0};
  assign hi_addr       = {offset[ADDR_W:2], 1'b1};
  assign unused_offset = ^{offset[31:ADDR_W+1], offset[1:0]};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_IDLE: if (request) begin
        state_n = ST_LO;
        cnt_n   = '0;
      end
      ST_LO: if (last) begin
        state_n = ST_HI;
        cnt_n   = '0;
      end else begin
        cnt_n   = cnt + CNT_W'(1);
      end
      ST_HI: if (last) begin
        state_n = ST_DONE;
        cnt_n   = '0;
      end else begin
        cnt_n   = cnt + CNT_W'(1);
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // NOTE: request holding registers and the low-half read buffer are pure
  // datapath, always written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && request) begin
      wr_q    <= bus.mem_write;
      addr_q  <= bus.address;
      wdata_q <= bus.wdata;
    end
    if (state == ST_LO && last && !wr_q) begin
      lo_buf <= bus.sram_dq_in;
    end
  end

  // SRAM pins are registered from the next state, so they line up with the phase cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      if (state_n == ST_LO) begin
        sram_addr_q <= lo_addr;
        if (cur_wr) dq_out_q <= cur_wdata[15:0];
      end else if (state_n == ST_HI) begin
        sram_addr_q <= hi_addr;
        if (cur_wr) dq_out_q <= cur_wdata[31:16];
      end
      dq_oe_q <= cur_wr & in_phase(state_n);
      we_n_q  <= ~(cur_wr & in_phase(state_n) & (cnt_n != CNT_LAST));
      if (state == ST_HI && last && !wr_q) begin
        rdata_q <= {bus.sram_dq_in, lo_buf};
      end
    end
  end

`ifdef SRAM_POSTED_WRITE_EN
  logic posted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      posted_q <= 1'b0;
    end else if (state == ST_IDLE && request) begin
      posted_q <= bus.mem_write;
    end else if (state == ST_DONE) begin
      posted_q <= 1'b0;
    end
  end

  // A posted store is released immediately; anything queued behind it waits for the drain.
  always_comb begin
    ready_c = 1'b0;
    if (state == ST_IDLE) begin
      ready_c = ~request | bus.mem_write;
    end else if (posted_q) begin
      ready_c = ~request;
    end else begin
      ready_c = (state == ST_DONE);
    end
  end
`else
  always_comb begin
    ready_c = 1'b0;
    if (state == ST_IDLE) ready_c = ~request;
    if (state == ST_DONE) ready_c = 1'b1;
  end
`endif

  assign bus.rdata       = rdata_q;
  assign bus.ready       = ready_c;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = dq_oe_q;
  assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl (WAIT_CYCLES=1, BASE_ADDR=1024) with a
// behavioural 16-bit SRAM; posted-write sequence runs when SRAM_POSTED_WRITE_EN is defined.
module tb_sram_mem_ctrl;
  import sram_mem_ctrl_pkg::*;

  localparam int ADDR_W = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  sram_mem_ctrl #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (1),
    .BASE_ADDR   (32'd1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model: 64 half-words preloaded with A000+index while rst is high.
  logic [15:0]       mem [64];
  logic [ADDR_W-1:0] wlog_a [$];
  logic [15:0]       wlog_d [$];
  logic              wlog_oe [$];

  assign bus.sram_dq_in = mem[bus.sram_addr[5:0]];

  always @(posedge clk) begin
    if (!bus.sram_we_n) begin
      wlog_a.push_back(bus.sram_addr);
      wlog_d.push_back(bus.sram_dq_out);
      wlog_oe.push_back(bus.sram_dq_oe);
    end
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'hA000 + 16'(i);
    end else if (!bus.sram_we_n) begin
      mem[bus.sram_addr[5:0]] <= bus.sram_dq_out;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.address   = a;
    bus.wdata     = d;
  endtask

  // Presents a request just after a rising edge and samples on falling edges
  // until ready is seen; the caller's next request lands on the following edge.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int low, output logic [31:0] rdv,
                        output logic [ADDR_W-1:0] tr1, output logic [ADDR_W-1:0] tr3);
    logic [ADDR_W-1:0] tr [$];
    logic done;
    done = 1'b0;
    low  = 0;
    rdv  = '0;
    @(posedge clk); #1;
    drive(rd, wr, a, d);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        done = 1'b1;
        rdv  = bus.rdata;
      end else begin
        tr.push_back(bus.sram_addr);
        low++;
      end
    end
    check("ready_within_budget", 32'(done), 32'd1);
    tr1 = (tr.size() > 1) ? tr[1] : '0;
    tr3 = (tr.size() > 3) ? tr[3] : '0;
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  typedef struct {
    logic              rd;
    logic              wr;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] exp_lo;
    logic [ADDR_W-1:0] exp_hi;
    int                exp_nwr;
    logic [31:0]       exp_rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int                low;
    logic [31:0]       rdv;
    logic [ADDR_W-1:0] tr1, tr3;
    int                n0;

    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int                low;
    logic [31:0]       rdv;
    logic [ADDR_W-1:0] tr1, tr3;
    int                n0;

    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0, 18'd1, 2, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        18'd0, 18'd1, 0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'd1028, 32'h0,        18'd2, 18'd3, 0, 32'hA003A002};
    vecs[3] = '{1'b0, 1'b1, 32'd1032, 32'h12345678, 18'd4, 18'd5, 2, 32'hA003A002};
    vecs[4] = '{1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 18'd8, 18'd9, 2, 32'hA003A002};
    vecs[5] = '{1'b1, 1'b0, 32'd1043, 32'h0,        18'd8, 18'd9, 0, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 32'd1036, 32'h0,        18'd6, 18'd7, 0, 32'hA007A006};
    vecs[7] = '{1'b1, 1'b0, 32'd1000, 32'h0,   18'h3FFF4, 18'h3FFF5, 0, 32'hA035A034};

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready",     32'(bus.ready),       32'd1);
    check("reset_we_n",      32'(bus.sram_we_n),   32'd1);
    check("reset_oe",        32'(bus.sram_dq_oe),  32'd0);
    check("reset_rdata",     bus.rdata,            32'd0);
    check("reset_sram_addr", 32'(bus.sram_addr),   32'd0);
    check("reset_dq_out",    32'(bus.sram_dq_out), 32'd0);

    // Back-to-back transactions: each vector is issued on the DONE edge of the previous one.
    for (int v = 0; v < 8; v++) begin
      n0 = wlog_a.size();
      access(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, low, rdv, tr1, tr3);
      check($sformatf("v%0d_freeze_cycles", v), 32'(low), 32'd5);
      check($sformatf("v%0d_lo_addr", v), 32'(tr1), 32'(vecs[v].exp_lo));
      check($sformatf("v%0d_hi_addr", v), 32'(tr3), 32'(vecs[v].exp_hi));
      check($sformatf("v%0d_rdata", v), rdv, vecs[v].exp_rdata);
      check($sformatf("v%0d_write_strobes", v), 32'(wlog_a.size() - n0), 32'(vecs[v].exp_nwr));
      if (vecs[v].exp_nwr == 2 && wlog_a.size() >= n0 + 2) begin
        check($sformatf("v%0d_strobe0_addr", v), 32'(wlog_a[n0]),    32'(vecs[v].exp_lo));
        check($sformatf("v%0d_strobe0_data", v), 32'(wlog_d[n0]),    32'(vecs[v].wdata[15:0]));
        check($sformatf("v%0d_strobe0_oe", v),   32'(wlog_oe[n0]),   32'd1);
        check($sformatf("v%0d_strobe1_addr", v), 32'(wlog_a[n0+1]),  32'(vecs[v].exp_hi));
        check($sformatf("v%0d_strobe1_data", v), 32'(wlog_d[n0+1]),  32'(vecs[v].wdata[31:16]));
        check($sformatf("v%0d_strobe1_oe", v),   32'(wlog_oe[n0+1]), 32'd1);
      end
    end
    go_idle();
    repeat (3) @(negedge clk);
    check("rdata_held",     bus.rdata,           32'hA035A034);
    check("idle_ready",     32'(bus.ready),      32'd1);
    check("idle_we_n",      32'(bus.sram_we_n),  32'd1);
    check("idle_oe",        32'(bus.sram_dq_oe), 32'd0);
    check("idle_addr_hold", 32'(bus.sram_addr),  32'h3FFF5);

`ifdef SRAM_POSTED_WRITE_EN
    access(1'b0, 1'b1, 32'd1056, 32'h55AA33CC, low, rdv, tr1, tr3);
    check("posted_store_no_freeze", 32'(low), 32'd0);
    access(1'b1, 1'b0, 32'd1056, 32'h0, low, rdv, tr1, tr3);
    check("posted_load_freeze", 32'(low), 32'd10);
    check("posted_load_rdata",  rdv,      32'h55AA33CC);
    go_idle();
    repeat (2) @(negedge clk);
`endif

    // Reset in the first HI cycle of a store (word 6 -> half-words 12/13).
    n0 = wlog_a.size();
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'd1048, 32'h11112222);
    repeat (4) @(negedge clk);
    check("midhi_we_n",      32'(bus.sram_we_n), 32'd0);
    check("midhi_sram_addr", 32'(bus.sram_addr), 32'd13);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_we_n",  32'(bus.sram_we_n),  32'd1);
    check("abort_oe",    32'(bus.sram_dq_oe), 32'd0);
    check("abort_rdata", bus.rdata,           32'd0);
    check("abort_ready", 32'(bus.ready),      32'd1);
    repeat (4) @(negedge clk);
    check("abort_no_more_strobes", 32'(wlog_a.size() - n0), 32'd2);
    check("abort_stays_idle",      32'(bus.ready),          32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
